// File: rtl/shift_pipe.sv
// shift_pipe: pipelined shift/rotate execution unit for the integer backend.
// It accepts one shift micro-op per cycle. After STAGES cycles it returns the
// result tagged with the op's physical destination register.
//
// Parameters:
//   XLEN   - datapath width, 32 or 64 (W-forms only exist when XLEN = 64)
//   RB     - rename bits; destination tags are 5+RB wide
//   STAGES - pipeline depth, 1 or 2
//   ROT_EN - 0 removes the rotate datapath (rol/ror then yield 0)
//
// Ports:
//   CLK, RSTn                   clock (rising edge), async active-low reset
//   flush                       kill every in-flight op at the next edge
//   shift_exeparam_vaild/ready  issue handshake
//   op_sll..op_ror, is32w       one-hot operation select, W-form flag
//   shift_rd0_dnxt              destination tag of the issued op
//   op1, op2                    value to shift, shift amount source
//   shift_writeback_vaild/ready writeback handshake
//   shift_res_qout              result
//   shift_rd0_qout              result tag
module shift_pipe #(
    parameter int XLEN   = 64,
    parameter int RB     = 6,
    parameter int STAGES = 2,
    parameter int ROT_EN = 1
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            flush,
    input  logic            shift_exeparam_vaild,
    output logic            shift_exeparam_ready,
    input  logic            op_sll,
    input  logic            op_srl,
    input  logic            op_sra,
    input  logic            op_rol,
    input  logic            op_ror,
    input  logic            is32w,
    input  logic [4+RB:0]   shift_rd0_dnxt,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            shift_writeback_vaild,
    input  logic            shift_writeback_ready,
    output logic [XLEN-1:0] shift_res_qout,
    output logic [4+RB:0]   shift_rd0_qout
);

    localparam int SHW  = $clog2(XLEN);
    localparam int TAGW = 5 + RB;

    if (STAGES != 1 && STAGES != 2) begin : gBadStages
        $error("shift_pipe: STAGES must be 1 or 2");
    end
    if (XLEN != 32 && XLEN != 64) begin : gBadXlen
        $error("shift_pipe: XLEN must be 32 or 64");
    end

    logic [4:0]      opVec;
    logic            isW;
    logic [XLEN-1:0] srcExt;
    logic [SHW-1:0]  shAmt;
    logic            outValid_q;
    logic [XLEN-1:0] outRes_q;
    logic [TAGW-1:0] outRd_q;
    logic            unusedOp2;

    assign opVec     = {op_ror, op_rol, op_sra, op_srl, op_sll};
    assign isW       = (XLEN == 64) && is32w;
    assign unusedOp2 = ^op2[XLEN-1:SHW];

    // Applies every selected operation by 'amt' and ORs the results. A shift
    // by a+b equals a shift by a followed by b, so the coarse and fine stages
    // reuse this. W rotates wrap within the low 32 bits; the upper bits are
    // overwritten later by the W sign extension.
    function automatic logic [XLEN-1:0] shiftBy(input logic [XLEN-1:0] x,
                                                input logic [SHW-1:0]  amt,
                                                input logic [4:0]      op,
                                                input logic            w);
        logic [XLEN-1:0]   r;
        logic [2*XLEN-1:0] rl;
        logic [2*XLEN-1:0] rr;
        logic [63:0]       rl32;
        logic [63:0]       rr32;
        r = '0;
        if (op[0]) r = r | (x << amt);
        if (op[1]) r = r | (x >> amt);
        if (op[2]) r = r | $unsigned($signed(x) >>> amt);
        if (ROT_EN != 0 && (op[3] || op[4])) begin
            if (w) begin
                rl32 = {x[31:0], x[31:0]} << amt[4:0];
                rr32 = {x[31:0], x[31:0]} >> amt[4:0];
                r[31:0] = r[31:0] | (op[3] ? rl32[63:32] : '0) | (op[4] ? rr32[31:0] : '0);
            end else begin
                rl = {x, x} << amt;
                rr = {x, x} >> amt;
                r = r | (op[3] ? rl[2*XLEN-1:XLEN] : '0) | (op[4] ? rr[XLEN-1:0] : '0);
            end
        end
        return r;
    endfunction

    // W-form results carry bit 31 into the upper half.
    function automatic logic [XLEN-1:0] wExtend(input logic [XLEN-1:0] x, input logic w);
        logic [XLEN-1:0] r;
        r = x;
        if (w) begin
            for (int i = 32; i < XLEN; i++) r[i] = x[31];
        end
        return r;
    endfunction

    // W-forms shift a 32-bit source. Widening it with its sign (SRA) or zeros
    // lets the full-width right shifts produce the correct low 32 bits.
    always_comb begin
        srcExt = op1;
        shAmt  = op2[SHW-1:0];
        if (isW) begin
            for (int i = 32; i < XLEN; i++) srcExt[i] = op_sra & op1[31];
            for (int i = 5; i < SHW; i++) shAmt[i] = 1'b0;
        end
    end

    if (STAGES == 1) begin : gOneStage
        logic            outLoad;
        logic            accept;
        logic            outValid_d;
        logic [XLEN-1:0] outRes_d;

        always_comb begin
            outLoad    = ~outValid_q | shift_writeback_ready;
            accept     = shift_exeparam_vaild & outLoad;
            outValid_d = flush ? 1'b0 : (outLoad ? accept : outValid_q);
            outRes_d   = wExtend(shiftBy(srcExt, shAmt, opVec, isW), isW);
        end

        assign shift_exeparam_ready = outLoad;

        always_ff @(posedge CLK or negedge RSTn) begin
            if (!RSTn) begin
                outValid_q <= 1'b0;
                outRes_q   <= '0;
                outRd_q    <= '0;
            end else begin
                outValid_q <= outValid_d;
                if (accept) begin
                    outRes_q <= outRes_d;
                    outRd_q  <= shift_rd0_dnxt;
                end
            end
        end
    end else if (STAGES == 2) begin : gTwoStage
        logic            s1Valid_q;
        logic [XLEN-1:0] s1Data_q;
        logic [4:0]      s1Op_q;
        logic            s1W_q;
        logic [2:0]      s1Fine_q;
        logic [TAGW-1:0] s1Rd_q;
        logic            outLoad;
        logic            s1Advance;
        logic            ready;
        logic            accept;
        logic            s1Valid_d;
        logic            outValid_d;
        logic [SHW-1:0]  coarseAmt;
        logic [SHW-1:0]  fineAmt;
        logic [XLEN-1:0] s1Data_d;
        logic [XLEN-1:0] outRes_d;

        // A stage loads when it is empty or its contents move on this cycle.
        always_comb begin
            outLoad        = ~outValid_q | shift_writeback_ready;
            s1Advance      = s1Valid_q & outLoad;
            ready          = ~s1Valid_q | s1Advance;
            accept         = shift_exeparam_vaild & ready;
            s1Valid_d      = flush ? 1'b0 : (ready ? accept : s1Valid_q);
            outValid_d     = flush ? 1'b0 : (outLoad ? s1Valid_q : outValid_q);
            coarseAmt      = shAmt;
            coarseAmt[2:0] = 3'b000;
            fineAmt        = '0;
            fineAmt[2:0]   = s1Fine_q;
            s1Data_d       = shiftBy(srcExt, coarseAmt, opVec, isW);
            outRes_d       = wExtend(shiftBy(s1Data_q, fineAmt, s1Op_q, s1W_q), s1W_q);
        end

        assign shift_exeparam_ready = ready;

        always_ff @(posedge CLK or negedge RSTn) begin
            if (!RSTn) begin
                s1Valid_q  <= 1'b0;
                s1Data_q   <= '0;
                s1Op_q     <= '0;
                s1W_q      <= 1'b0;
                s1Fine_q   <= '0;
                s1Rd_q     <= '0;
                outValid_q <= 1'b0;
                outRes_q   <= '0;
                outRd_q    <= '0;
            end else begin
                s1Valid_q  <= s1Valid_d;
                outValid_q <= outValid_d;
                if (accept) begin
                    s1Data_q <= s1Data_d;
                    s1Op_q   <= opVec;
                    s1W_q    <= isW;
                    s1Fine_q <= shAmt[2:0];
                    s1Rd_q   <= shift_rd0_dnxt;
                end
                if (s1Advance) begin
                    outRes_q <= outRes_d;
                    outRd_q  <= s1Rd_q;
                end
            end
        end
    end

    assign shift_writeback_vaild = outValid_q;
    assign shift_res_qout        = outRes_q;
    assign shift_rd0_qout        = outRd_q;

endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe. Two instances share the stimulus: dut0 (STAGES=2,
// ROT_EN=1) and dut1 (STAGES=1, ROT_EN=0). A behavioural scoreboard per
// instance predicts ready, valid, result and tag every cycle.
module tb_shift_pipe;

    localparam int TAGW = 11;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        flush;
    logic        vaild;
    logic        wbReady;
    logic        is32w;
    int          curOp;
    logic [10:0] rdIn;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [1:0]  rdy;
    logic [1:0]  wbValid;
    logic [63:0] resOut [2];
    logic [10:0] rdOut [2];

    int vectors = 0;
    int miscompares = 0;

    // Scoreboard: ring buffer of in-flight ops per instance
    logic [63:0] eRes [2][4];
    logic [10:0] eRd [2][4];
    int          eAge [2][4];
    int          head [2] = '{0, 0};
    int          cnt [2] = '{0, 0};

    always #5 CLK = ~CLK;

    shift_pipe #(.XLEN(64), .RB(6), .STAGES(2), .ROT_EN(1)) dut0 (
        .CLK(CLK), .RSTn(RSTn), .flush(flush),
        .shift_exeparam_vaild(vaild), .shift_exeparam_ready(rdy[0]),
        .op_sll(curOp == 0), .op_srl(curOp == 1), .op_sra(curOp == 2),
        .op_rol(curOp == 3), .op_ror(curOp == 4), .is32w(is32w),
        .shift_rd0_dnxt(rdIn), .op1(op1), .op2(op2),
        .shift_writeback_vaild(wbValid[0]), .shift_writeback_ready(wbReady),
        .shift_res_qout(resOut[0]), .shift_rd0_qout(rdOut[0])
    );

    shift_pipe #(.XLEN(64), .RB(6), .STAGES(1), .ROT_EN(0)) dut1 (
        .CLK(CLK), .RSTn(RSTn), .flush(flush),
        .shift_exeparam_vaild(vaild), .shift_exeparam_ready(rdy[1]),
        .op_sll(curOp == 0), .op_srl(curOp == 1), .op_sra(curOp == 2),
        .op_rol(curOp == 3), .op_ror(curOp == 4), .is32w(is32w),
        .shift_rd0_dnxt(rdIn), .op1(op1), .op2(op2),
        .shift_writeback_vaild(wbValid[1]), .shift_writeback_ready(wbReady),
        .shift_res_qout(resOut[1]), .shift_rd0_qout(rdOut[1])
    );

    function automatic int stagesOf(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic bit rotOf(input int d);
        return d == 0;
    endfunction

    // Reference result straight from the instruction definitions.
    // op: 0 sll, 1 srl, 2 sra, 3 rol, 4 ror, 5 none
    function automatic logic [63:0] refResult(input int op, input bit w, input logic [63:0] a,
                                              input logic [63:0] b, input bit rotEn);
        int          s;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] r;
        r = '0;
        if (w) begin
            s = int'(b[4:0]);
            x = a[31:0];
            y = '0;
            case (op)
                0: y = x << s;
                1: y = x >> s;
                2: y = $unsigned($signed(x) >>> s);
                3: if (rotEn) y = (s == 0) ? x : ((x << s) | (x >> (32 - s)));
                4: if (rotEn) y = (s == 0) ? x : ((x >> s) | (x << (32 - s)));
                default: y = '0;
            endcase
            r = {{32{y[31]}}, y};
        end else begin
            s = int'(b[5:0]);
            case (op)
                0: r = a << s;
                1: r = a >> s;
                2: r = $unsigned($signed(a) >>> s);
                3: if (rotEn) r = (s == 0) ? a : ((a << s) | (a >> (64 - s)));
                4: if (rotEn) r = (s == 0) ? a : ((a >> s) | (a << (64 - s)));
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    // Oldest op is at the output once it has spent STAGES-1 edges in the pipe
    function automatic bit expValid(input int d);
        return cnt[d] > 0 && eAge[d][head[d]] >= stagesOf(d) - 1;
    endfunction

    // The pipe holds STAGES ops at most; when full, room appears only as the output retires
    function automatic bit expReady(input int d);
        return cnt[d] < stagesOf(d) || wbReady;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int op, input bit w, input logic [63:0] a,
                                 input logic [63:0] b, input logic [10:0] tag, input bit v);
        curOp = op;
        is32w = w;
        op1   = a;
        op2   = b;
        rdIn  = tag;
        vaild = v;
    endtask

    task automatic stepEdge();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard update on every edge; uses only bench-side signals
    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int d = 0; d < 2; d++) begin
                cnt[d]  = 0;
                head[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                bit v;
                bit r;
                int idx;
                v = expValid(d);
                r = expReady(d);
                if (flush) begin
                    cnt[d] = 0;
                end else begin
                    if (v && wbReady) begin
                        head[d] = (head[d] + 1) % 4;
                        cnt[d]--;
                    end
                    for (int k = 0; k < cnt[d]; k++) eAge[d][(head[d] + k) % 4]++;
                    if (vaild && r) begin
                        idx = (head[d] + cnt[d]) % 4;
                        eRes[d][idx] = refResult(curOp, is32w, op1, op2, rotOf(d));
                        eRd[d][idx]  = rdIn;
                        eAge[d][idx] = 0;
                        cnt[d]++;
                    end
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge CLK) begin
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("ready[%0d]", d), {63'd0, rdy[d]}, {63'd0, expReady(d)});
            checkOutput($sformatf("valid[%0d]", d), {63'd0, wbValid[d]}, {63'd0, expValid(d)});
            if (expValid(d)) begin
                checkOutput($sformatf("res[%0d]", d), resOut[d], eRes[d][head[d]]);
                checkOutput($sformatf("tag[%0d]", d), {53'd0, rdOut[d]}, {53'd0, eRd[d][head[d]]});
            end
        end
    end

    // Issue one op on an idle pipe and check both instances against literals
    task automatic checkLiteral(input string name, input int op, input bit w,
                                input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] exp0, input logic [63:0] exp1,
                                input logic [10:0] tag);
        checkOutput({name, " model"}, refResult(op, w, a, b, 1'b1), exp0);
        checkOutput({name, " model rot-off"}, refResult(op, w, a, b, 1'b0), exp1);
        wbReady = 1'b1;
        applyStimulus(op, w, a, b, tag, 1'b1);
        stepEdge();
        applyStimulus(5, 1'b0, '0, '0, '0, 1'b0);
        checkOutput({name, " dut1 valid"}, {63'd0, wbValid[1]}, 64'd1);
        checkOutput({name, " dut1 res"}, resOut[1], exp1);
        checkOutput({name, " dut1 tag"}, {53'd0, rdOut[1]}, {53'd0, tag});
        checkOutput({name, " dut0 early valid"}, {63'd0, wbValid[0]}, 64'd0);
        stepEdge();
        checkOutput({name, " dut0 valid"}, {63'd0, wbValid[0]}, 64'd1);
        checkOutput({name, " dut0 res"}, resOut[0], exp0);
        checkOutput({name, " dut0 tag"}, {53'd0, rdOut[0]}, {53'd0, tag});
        stepEdge();
    endtask

    initial begin
        int          stallOp [4];
        bit          stallW [4];
        logic [63:0] stallA [4];
        logic [63:0] stallRes;
        int          issued;
        int          retires;

        RSTn    = 1'b0;
        flush   = 1'b0;
        wbReady = 1'b1;
        applyStimulus(5, 1'b0, '0, '0, '0, 1'b0);
        stepEdge();
        stepEdge();

        // Reset state
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("reset valid[%0d]", d), {63'd0, wbValid[d]}, 64'd0);
            checkOutput($sformatf("reset res[%0d]", d), resOut[d], 64'd0);
            checkOutput($sformatf("reset tag[%0d]", d), {53'd0, rdOut[d]}, 64'd0);
            checkOutput($sformatf("reset ready[%0d]", d), {63'd0, rdy[d]}, 64'd1);
        end
        RSTn = 1'b1;
        stepEdge();

        // Directed literal results
        checkLiteral("sra64", 2, 1'b0, 64'h8000_0000_0000_0000, 64'd63,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 11'h155);
        checkLiteral("sllw", 0, 1'b1, 64'h0000_0000_4000_0001, 64'd1,
                     64'hFFFF_FFFF_8000_0002, 64'hFFFF_FFFF_8000_0002, 11'h002);
        checkLiteral("srlw", 1, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd31,
                     64'h1, 64'h1, 11'h003);
        checkLiteral("ror", 4, 1'b0, 64'h1, 64'd1, 64'h8000_0000_0000_0000, 64'h0, 11'h004);
        checkLiteral("rorw", 4, 1'b1, 64'h1, 64'd1, 64'hFFFF_FFFF_8000_0000, 64'h0, 11'h005);
        checkLiteral("rol0", 3, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0,
                     64'h1234_5678_9ABC_DEF0, 64'h0, 11'h006);
        checkLiteral("rol60", 3, 1'b0, 64'hF, 64'd60, 64'hF000_0000_0000_0000, 64'h0, 11'h007);
        checkLiteral("rolw", 3, 1'b1, 64'hAAAA_AAAA_8000_0001, 64'd4, 64'h18, 64'h0, 11'h008);
        checkLiteral("sraw", 2, 1'b1, 64'h0000_0000_8000_0000, 64'd4,
                     64'hFFFF_FFFF_F800_0000, 64'hFFFF_FFFF_F800_0000, 11'h009);
        checkLiteral("sll-hibits", 0, 1'b0, 64'h1, 64'hFFFF_FFFF_FFFF_FFC4,
                     64'h10, 64'h10, 11'h00A);
        checkLiteral("noop", 5, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'd3, 64'h0, 64'h0, 11'h7FF);

        // Back-to-back issue with a 3-cycle writeback stall
        stallOp = '{0, 2, 4, 1};
        stallW  = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) stallA[i] = {$urandom, $urandom};
        stallRes = refResult(stallOp[0], stallW[0], stallA[0], 64'd13, 1'b1);
        issued   = 0;
        retires  = 0;
        for (int k = 0; k < 14; k++) begin
            wbReady = !(k >= 2 && k <= 4);
            if (issued < 4)
                applyStimulus(stallOp[issued], stallW[issued], stallA[issued], 64'd13,
                              11'(16 + issued), 1'b1);
            else
                vaild = 1'b0;
            @(negedge CLK);
            if (k >= 2 && k <= 4) begin
                checkOutput("stall ready", {63'd0, rdy[0]}, 64'd0);
                checkOutput("stall valid", {63'd0, wbValid[0]}, 64'd1);
                checkOutput("stall res", resOut[0], stallRes);
                checkOutput("stall tag", {53'd0, rdOut[0]}, 64'd16);
            end
            if (wbValid[0] && wbReady) retires++;
            if (vaild && rdy[0]) issued++;
            stepEdge();
        end
        checkOutput("stall issued", 64'(issued), 64'd4);
        checkOutput("stall retire count", 64'(retires), 64'd4);

        // Flush with two ops in flight and one being accepted
        wbReady = 1'b1;
        applyStimulus(0, 1'b0, 64'h11, 64'd1, 11'h020, 1'b1);
        stepEdge();
        applyStimulus(1, 1'b0, 64'h22, 64'd1, 11'h021, 1'b1);
        stepEdge();
        applyStimulus(2, 1'b0, 64'h33, 64'd1, 11'h022, 1'b1);
        flush = 1'b1;
        stepEdge();
        flush = 1'b0;
        applyStimulus(1, 1'b0, 64'h100, 64'd4, 11'h023, 1'b1);
        checkOutput("flush valid0", {63'd0, wbValid[0]}, 64'd0);
        checkOutput("flush valid1", {63'd0, wbValid[1]}, 64'd0);
        checkOutput("flush ready0", {63'd0, rdy[0]}, 64'd1);
        checkOutput("flush ready1", {63'd0, rdy[1]}, 64'd1);
        stepEdge();
        applyStimulus(5, 1'b0, '0, '0, '0, 1'b0);
        checkOutput("post-flush valid0", {63'd0, wbValid[0]}, 64'd0);
        stepEdge();
        checkOutput("post-flush new valid", {63'd0, wbValid[0]}, 64'd1);
        checkOutput("post-flush new res", resOut[0], 64'h10);
        checkOutput("post-flush new tag", {53'd0, rdOut[0]}, 64'h023);
        stepEdge();

        // Asynchronous reset in the middle of a stall
        wbReady = 1'b0;
        applyStimulus(0, 1'b0, 64'h5, 64'd2, 11'h030, 1'b1);
        stepEdge();
        applyStimulus(0, 1'b0, 64'h6, 64'd2, 11'h031, 1'b1);
        stepEdge();
        vaild = 1'b0;
        stepEdge();
        #2 RSTn = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("async reset valid[%0d]", d), {63'd0, wbValid[d]}, 64'd0);
            checkOutput($sformatf("async reset res[%0d]", d), resOut[d], 64'd0);
            checkOutput($sformatf("async reset tag[%0d]", d), {53'd0, rdOut[d]}, 64'd0);
            checkOutput($sformatf("async reset ready[%0d]", d), {63'd0, rdy[d]}, 64'd1);
        end
        @(posedge CLK);
        #2 RSTn = 1'b1;
        wbReady = 1'b1;
        stepEdge();
        checkOutput("after reset ready", {63'd0, rdy[0]}, 64'd1);
        checkOutput("after reset valid", {63'd0, wbValid[0]}, 64'd0);

        // Randomized traffic, checked every cycle by the scoreboard
        for (int n = 0; n < 600; n++) begin
            applyStimulus(int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                          {$urandom, $urandom},
                          ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 63)),
                          11'($urandom_range(0, 2047)), $urandom_range(0, 3) != 0);
            wbReady = $urandom_range(0, 2) != 0;
            flush   = $urandom_range(0, 24) == 0;
            stepEdge();
        end
        flush   = 1'b0;
        vaild   = 1'b0;
        wbReady = 1'b1;
        for (int n = 0; n < 5; n++) stepEdge();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
